// File: rtl/enc_layer.sv
// Fixed-point dense layer y = sat((W*x + b) >> FRAC), one column per cycle, all rows in parallel.
// Optional ReLU on the saturated outputs when ENC_RELU_EN is defined.
module enc_layer #(
    parameter int unsigned BITSIZE = 16,
    parameter int unsigned FRAC    = 11,
    parameter int unsigned N_IN    = 6,
    parameter int unsigned N_OUT   = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [BITSIZE*N_OUT*N_IN-1:0]    w,
    input  logic [BITSIZE*N_IN-1:0]          x,
    input  logic [BITSIZE*N_OUT-1:0]         b,
    output logic [BITSIZE*N_OUT-1:0]         y,
    output logic                             busy,
    output logic                             done
);

    localparam int unsigned PROD_W = 2 * BITSIZE;
    localparam int unsigned ACC_W  = 2 * BITSIZE + $clog2(N_IN) + 1;
    localparam int unsigned CNT_W  = (N_IN > 1) ? $clog2(N_IN) : 1;

`ifdef ENC_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                     state;
    logic [CNT_W-1:0]           cnt;
    logic signed [BITSIZE-1:0]  w_q [N_OUT][N_IN];
    logic signed [BITSIZE-1:0]  x_q [N_IN];
    logic signed [ACC_W-1:0]    acc_q [N_OUT];

    logic signed [PROD_W-1:0]   prod_c  [N_OUT];
    logic signed [ACC_W-1:0]    acc_mac_c [N_OUT];
    logic signed [ACC_W-1:0]    shr_c   [N_OUT];
    logic [BITSIZE-1:0]         y_sat_c [N_OUT];

    // One column of products per cycle, added into each row accumulator
    always_comb begin
        for (int unsigned r = 0; r < N_OUT; r++) begin
            prod_c[r]    = PROD_W'(w_q[r][cnt]) * PROD_W'(x_q[cnt]);
            acc_mac_c[r] = acc_q[r] + ACC_W'(prod_c[r]);
        end
    end

    // Rescale by FRAC (floor), clamp to the word range, then optional ReLU
    always_comb begin
        for (int unsigned r = 0; r < N_OUT; r++) begin
            shr_c[r] = acc_q[r] >>> FRAC;
            if (shr_c[r][ACC_W-1:BITSIZE-1] == '0 || shr_c[r][ACC_W-1:BITSIZE-1] == '1)
                y_sat_c[r] = shr_c[r][BITSIZE-1:0];
            else if (shr_c[r][ACC_W-1])
                y_sat_c[r] = {1'b1, {(BITSIZE-1){1'b0}}};
            else
                y_sat_c[r] = {1'b0, {(BITSIZE-1){1'b1}}};
            if (RELU && y_sat_c[r][BITSIZE-1])
                y_sat_c[r] = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            y     <= '0;
            for (int unsigned r = 0; r < N_OUT; r++) begin
                acc_q[r] <= '0;
                for (int unsigned c = 0; c < N_IN; c++)
                    w_q[r][c] <= '0;
            end
            for (int unsigned c = 0; c < N_IN; c++)
                x_q[c] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= MAC;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        for (int unsigned r = 0; r < N_OUT; r++) begin
                            acc_q[r] <= ACC_W'($signed(b[r*BITSIZE +: BITSIZE])) <<< FRAC;
                            for (int unsigned c = 0; c < N_IN; c++)
                                w_q[r][c] <= w[(r*N_IN+c)*BITSIZE +: BITSIZE];
                        end
                        for (int unsigned c = 0; c < N_IN; c++)
                            x_q[c] <= x[c*BITSIZE +: BITSIZE];
                    end
                end
                MAC: begin
                    for (int unsigned r = 0; r < N_OUT; r++)
                        acc_q[r] <= acc_mac_c[r];
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(N_IN - 1))
                        state <= OUT;
                end
                OUT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    for (int unsigned r = 0; r < N_OUT; r++)
                        y[r*BITSIZE +: BITSIZE] <= y_sat_c[r];
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enc_layer.sv
// Directed self-checking bench for enc_layer (N_OUT=1 and N_OUT=2 instances).
module tb_enc_layer;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [95:0]  w;
    logic [95:0]  x;
    logic [15:0]  b;
    logic [15:0]  y;
    logic         busy;
    logic         done;

    logic [191:0] w2;
    logic [95:0]  x2;
    logic [31:0]  b2;
    logic [31:0]  y2;
    logic         busy2;
    logic         done2;

    int n_assert = 0;
    int n_fail   = 0;
    int lat;
    int cnt_done;

    always #5 clk = ~clk;

    enc_layer #(.BITSIZE(16), .FRAC(11), .N_IN(6), .N_OUT(1)) dut (
        .clk(clk), .reset(reset), .start(start),
        .w(w), .x(x), .b(b), .y(y), .busy(busy), .done(done)
    );

    enc_layer #(.BITSIZE(16), .FRAC(11), .N_IN(6), .N_OUT(2)) dut2 (
        .clk(clk), .reset(reset), .start(start),
        .w(w2), .x(x2), .b(b2), .y(y2), .busy(busy2), .done(done2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // Counts edges from the accept edge until done rises (bounded)
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done && n < 20);
    endtask

    task automatic run_pulse(output int n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n);
    endtask

    task automatic set_base;
        for (int i = 0; i < 6; i++) begin
            w[i*16 +: 16] = (i % 2 == 0) ? 16'h1000 : 16'h0800;
            x[i*16 +: 16] = (i % 2 == 0) ? 16'h0800 : 16'h1000;
        end
        b = 16'h0400;
    endtask

    task automatic set_all(input logic [15:0] wv, input logic [15:0] xv, input logic [15:0] bv);
        for (int i = 0; i < 6; i++) begin
            w[i*16 +: 16] = wv;
            x[i*16 +: 16] = xv;
        end
        b = bv;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        set_base();
        for (int i = 0; i < 6; i++) begin
            w2[i*16 +: 16]      = (i % 2 == 0) ? 16'h1000 : 16'h0800;
            w2[(6+i)*16 +: 16]  = 16'h0000;
            x2[i*16 +: 16]      = (i % 2 == 0) ? 16'h0800 : 16'h1000;
        end
        b2 = {16'hFC00, 16'h0400};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_y", 32'(y), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);

        // Release with start already high: first edge after release accepts
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'h1);
        wait_done(lat);
        chk("base_latency", 32'(lat), 32'd7);
        chk("base_y", 32'(y), 32'h6400);
        chk("base_busy_in_done", 32'(busy), 32'h0);
`ifdef ENC_RELU_EN
        chk("two_row_y", y2, 32'h0000_6400);
`else
        chk("two_row_y", y2, 32'hFC00_6400);
`endif
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'h0);
        chk("y_hold", 32'(y), 32'h6400);

        set_all(16'h1000, 16'h1000, 16'h0000);
        run_pulse(lat);
        chk("possat_latency", 32'(lat), 32'd7);
        chk("possat_y", 32'(y), 32'h7FFF);

        set_all(16'h8000, 16'h0800, 16'h0000);
        run_pulse(lat);
        chk("negsat_y", 32'(y), 32'h8000);

        set_all(16'hF800, 16'h0800, 16'h0000);
        run_pulse(lat);
`ifdef ENC_RELU_EN
        chk("neg6_y", 32'(y), 32'h0000);
`else
        chk("neg6_y", 32'(y), 32'hD000);
`endif

        // start held high; x zeroed right after accept must not disturb this run
        @(negedge clk);
        set_base();
        start = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) x[i*16 +: 16] = 16'h0000;
        wait_done(lat);
        chk("held_first_latency", 32'(lat), 32'd7);
        chk("held_capture_y", 32'(y), 32'h6400);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!done && lat < 20);
        start = 1'b0;
        chk("held_period", 32'(lat), 32'd8);
        chk("held_second_y", 32'(y), 32'h0400);

        // start pulse during MAC is dropped, not queued
        @(negedge clk);
        set_base();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_mid_mac", 32'(busy), 32'h1);
        lat = 3;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("ignore_latency", 32'(lat), 32'd7);
        chk("ignore_y", 32'(y), 32'h6400);
        cnt_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done || busy) cnt_done++;
        end
        chk("no_queued_start", 32'(cnt_done), 32'd0);

        // Async reset mid-MAC aborts the run
        set_all(16'h1000, 16'h1000, 16'h0000);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_y", 32'(y), 32'h0);
        chk("abort_y2", y2, 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        cnt_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) cnt_done++;
        end
        chk("abort_no_done", 32'(cnt_done), 32'd0);
        @(negedge clk);
        set_base();
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        chk("post_reset_latency", 32'(lat), 32'd7);
        chk("post_reset_y", 32'(y), 32'h6400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/enc_layer.md
ENC_LAYER -- requirements
Module: enc_layer

Interface
REQ-001 Parameter BITSIZE, default 16, width of every signed two's-complement fixed-point word.
REQ-002 Parameter FRAC, default 11, fractional bits (0x0800 = 1.0, 0x0400 = 0.5).
REQ-003 Parameter N_IN, default 6, input vector length and matrix columns.
REQ-004 Parameter N_OUT, default 1, output vector length and matrix rows.
REQ-005 clk  input  1  single clock, rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  request one evaluation; sampled only in IDLE.
REQ-008 w  input  BITSIZE*N_OUT*N_IN  flattened weights; element (r,c) at word index r*N_IN+c.
REQ-009 x  input  BITSIZE*N_IN  flattened input vector; element c at word index c.
REQ-010 b  input  BITSIZE*N_OUT  flattened bias; element r at word index r.
REQ-011 y  output  BITSIZE*N_OUT  flattened result; element r at word index r.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 done  output  1  one-cycle pulse when y is updated.

Function
REQ-014 States: IDLE, MAC, OUT; IDLE->MAC on start=1; MAC->OUT after N_IN MAC cycles; OUT->IDLE unconditionally.
REQ-015 On the edge that accepts start (edge k), w, x and b are captured into internal registers; later input changes do not affect the running evaluation.
REQ-016 On edge k, each of the N_OUT accumulators loads b[r] sign-extended and shifted left by FRAC.
REQ-017 On edges k+1 .. k+N_IN, accumulator r adds full-precision product w(r,c)*x(c), c = 0 .. N_IN-1 in ascending order; all rows in parallel.
REQ-018 Accumulator width is 2*BITSIZE + ceil(log2(N_IN)) + 1 bits; no overflow is possible inside the accumulator.
REQ-019 On edge k+N_IN+1, y[r] = accumulator arithmetically shifted right by FRAC (truncation toward minus infinity), saturated to [-2^(BITSIZE-1), 2^(BITSIZE-1)-1].
REQ-020 done is high for exactly the cycle following edge k+N_IN+1; latency start-accept to done = N_IN+1 cycles.
REQ-021 y holds its value between done pulses; it changes only on the done-producing edge or on reset.
REQ-022 start while busy=1 is ignored and not queued.
REQ-023 start high during the done cycle is accepted (state already IDLE), giving back-to-back evaluations every N_IN+2 cycles.
REQ-024 busy is high from the cycle after edge k through the cycle after edge k+N_IN; it is low during the done cycle.

Reset
REQ-025 reset low immediately forces state IDLE, y to all zeros, busy to 0, done to 0, accumulators and captured operands to 0, independent of clk.
REQ-026 reset asserted mid-evaluation aborts it; no done pulse is produced for the aborted evaluation.
REQ-027 The first start is accepted on the first rising edge after reset is released.

Configuration
REQ-028 Macro ENC_RELU_EN: when defined, each saturated y[r] with sign bit set is replaced by 0 (ReLU applied after saturation); when undefined, y[r] is the signed saturated value unchanged.

Verification
REQ-029 N_IN=6, N_OUT=1; w words 0x1000,0x0800 alternating; x words 0x0800,0x1000 alternating; b=0x0400; start pulse -> done exactly 7 cycles later, y=0x6400 (12.5).
REQ-030 Same config, all w=x=0x1000 (2.0), b=0 -> y=0x7FFF (positive saturation); all w=0x8000, x=0x8000... replaced by w=0x8000 (-16.0), x=0x0800 (1.0), b=0 -> y=0x8000 (negative saturation).
REQ-031 All w=0xF800 (-1.0), x=0x0800, b=0 -> y=0xD000 (-6.0) without ENC_RELU_EN; y=0x0000 with ENC_RELU_EN.
REQ-032 N_OUT=2: row0 as REQ-029, row1 all w=0 with b=0xFC00 -> y word0=0x6400, word1=0xFC00 (0xFC00 becomes 0x0000 with ENC_RELU_EN).
REQ-033 start held high continuously -> done every 8 cycles; x changed during MAC -> result reflects x captured at accept; start pulse at MAC cycle 3 ignored.
REQ-034 reset driven low at MAC cycle 3 between clock edges -> y=0, busy=0 immediately; no done; next start after release yields correct REQ-029 result.
